// File: rtl/wave_buffer_scheduler.sv
// Ping-pong buffer controller for the 512x8 waveform RAM: arbitrates the single
// RAM port between capture (writer) and display (reader) and sequences ownership swaps.
module wave_buffer_scheduler #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_req,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_done,
  output logic              cap_gnt,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_idle,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              read_index,
  output logic              buf_ready,
  output logic [7:0]        swap_count
);

  typedef enum logic [1:0] {FILLING, FULL, SWAP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_next;
  logic [3:0] starve_cnt, starve_next;

  // Grants are gated by reset so the RAM port stays quiet while held in reset.
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    cap_gnt     = 1'b0;
    disp_gnt    = 1'b0;
    buf_ready   = 1'b0;
    case (state)
      FILLING: begin
        if (reset) begin
          if (cap_req && (!disp_req || starve_cnt == STARVE_LIM))
            cap_gnt = 1'b1;
          else if (disp_req)
            disp_gnt = 1'b1;
        end
        if (cap_gnt || !cap_req)
          starve_next = 4'd0;
        else if (starve_cnt != STARVE_LIM)
          starve_next = starve_cnt + 4'd1;
        if (cap_done)
          state_next = FULL;
      end
      FULL: begin
        buf_ready   = 1'b1;
        disp_gnt    = disp_req && reset;
        starve_next = 4'd0;
        if (disp_idle)
          state_next = SWAP;
      end
      SWAP: begin
        starve_next = 4'd0;
        state_next  = FILLING;
      end
      default: state_next = FILLING;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILLING;
      starve_cnt  <= 4'd0;
      disp_rvalid <= 1'b0;
      read_index  <= 1'b0;
      swap_count  <= 8'd0;
    end else begin
      state       <= state_next;
      starve_cnt  <= starve_next;
      disp_rvalid <= disp_gnt;
      if (state == SWAP) begin
        read_index <= ~read_index;
        swap_count <= swap_count + 8'd1;
      end
    end
  end

  // Capture always targets the half the display does not own.
  assign ram_addr   = cap_gnt  ? {~read_index, cap_addr} :
                      disp_gnt ? {read_index, disp_addr} : '0;
  assign ram_we     = cap_gnt;
  assign ram_wdata  = cap_gnt ? cap_data : '0;
  assign disp_rdata = disp_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_wave_buffer_scheduler.sv
// Scoreboard bench for wave_buffer_scheduler: directed stimulus pushes expected
// RAM-port transactions; a negedge monitor pops and compares them.
module tb_wave_buffer_scheduler;

  logic       clk;
  logic       reset;
  logic       cap_req;
  logic [7:0] cap_addr;
  logic [7:0] cap_data;
  logic       cap_done;
  logic       cap_gnt;
  logic       disp_req;
  logic [7:0] disp_addr;
  logic       disp_idle;
  logic       disp_gnt;
  logic       disp_rvalid;
  logic [7:0] disp_rdata;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       read_index;
  logic       buf_ready;
  logic [7:0] swap_count;

  typedef struct {
    int         cyc;
    bit         we;
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  wave_buffer_scheduler #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .cap_req(cap_req), .cap_addr(cap_addr), .cap_data(cap_data),
    .cap_done(cap_done), .cap_gnt(cap_gnt),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_idle(disp_idle),
    .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .read_index(read_index), .buf_ready(buf_ready),
    .swap_count(swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous-read RAM stand-in returning a fixed address-dependent pattern.
  function automatic logic [7:0] pat(logic [8:0] a);
    return a[7:0] ^ (a[8] ? 8'hC3 : 8'h3C);
  endfunction

  always @(posedge clk) ram_rdata <= pat(ram_addr);

  task automatic check_output(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_write(logic [8:0] addr, logic [7:0] data);
    gq.push_back('{cyc, 1'b1, addr, data});
  endtask

  task automatic expect_read(logic [8:0] addr, bit with_data);
    gq.push_back('{cyc, 1'b0, addr, 8'h00});
    if (with_data) rq.push_back('{cyc + 1, 1'b0, 9'h0, pat(addr)});
  endtask

  task automatic apply_stimulus(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every grant and every rvalid must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (cap_gnt || disp_gnt) begin
      total++;
      if (gq.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_grant cyc=%0d: got cap=%0b disp=%0b addr=%0h expected none",
                 cyc, cap_gnt, disp_gnt, ram_addr);
      end else begin
        e = gq.pop_front();
        if (e.cyc != cyc || cap_gnt !== e.we || disp_gnt !== !e.we || ram_we !== e.we ||
            ram_addr !== e.addr || ram_wdata !== e.data) begin
          bad++;
          $display("[TB] FAIL grant cyc=%0d: got cap=%0b disp=%0b we=%0b addr=%0h wdata=%0h expected cyc=%0d we=%0b addr=%0h wdata=%0h",
                   cyc, cap_gnt, disp_gnt, ram_we, ram_addr, ram_wdata, e.cyc, e.we, e.addr, e.data);
        end
      end
    end else begin
      if (gq.size() > 0 && gq[0].cyc <= cyc) begin
        e = gq.pop_front();
        total++;
        bad++;
        $display("[TB] FAIL missing_grant cyc=%0d: got none expected we=%0b addr=%0h", cyc, e.we, e.addr);
      end
      total++;
      if (ram_addr !== 9'h0 || ram_we !== 1'b0 || ram_wdata !== 8'h0) begin
        bad++;
        $display("[TB] FAIL idle_port cyc=%0d: got addr=%0h we=%0b wdata=%0h expected 0", cyc, ram_addr, ram_we, ram_wdata);
      end
    end
    if (disp_rvalid) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_rvalid cyc=%0d: got 1 expected 0", cyc);
      end else begin
        e = rq.pop_front();
        if (e.cyc != cyc || disp_rdata !== e.data) begin
          bad++;
          $display("[TB] FAIL rdata cyc=%0d: got %0h expected %0h at cyc %0d", cyc, disp_rdata, e.data, e.cyc);
        end
      end
    end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
      e = rq.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL missing_rvalid cyc=%0d: got 0 expected data %0h", cyc, e.data);
    end
  end

  initial begin
    reset     = 1'b0;
    cap_req   = 1'b1;
    disp_req  = 1'b1;
    cap_addr  = 8'($urandom);
    cap_data  = 8'($urandom);
    cap_done  = 1'($urandom);
    disp_addr = 8'($urandom);
    disp_idle = 1'($urandom);
    apply_stimulus(3);
    check_output("rst_cap_gnt", 32'(cap_gnt), 0);
    check_output("rst_disp_gnt", 32'(disp_gnt), 0);
    check_output("rst_ram_addr", 32'(ram_addr), 0);
    check_output("rst_ram_we", 32'(ram_we), 0);
    check_output("rst_ram_wdata", 32'(ram_wdata), 0);
    check_output("rst_rvalid", 32'(disp_rvalid), 0);
    check_output("rst_rdata", 32'(disp_rdata), 0);
    check_output("rst_read_index", 32'(read_index), 0);
    check_output("rst_buf_ready", 32'(buf_ready), 0);
    check_output("rst_swap_count", 32'(swap_count), 0);

    cap_req = 0; disp_req = 0; cap_done = 0; disp_idle = 0;
    reset = 1'b1;

    // First write lands in half 1 since the display owns half 0.
    cap_req = 1; cap_addr = 8'h05; cap_data = 8'hA3;
    expect_write(9'h105, 8'hA3);
    apply_stimulus(1);
    cap_req = 0;
    disp_req = 1; disp_addr = 8'h10;
    expect_read(9'h010, 1);
    apply_stimulus(1);
    disp_req = 0;
    apply_stimulus(1);

    // Both requesting: D,D,D,C repeating.
    cap_req = 1; disp_req = 1; cap_addr = 8'h40;
    for (int i = 0; i < 8; i++) begin
      cap_data  = 8'h70 + 8'(i);
      disp_addr = 8'h20 + 8'(i);
      if (i % 4 == 3) expect_write(9'h140, 8'h70 + 8'(i));
      else            expect_read({1'b0, 8'h20 + 8'(i)}, 1);
      apply_stimulus(1);
    end
    cap_req = 0; disp_req = 0;
    apply_stimulus(1);

    // Swap with the display busy, then idle.
    cap_done = 1;
    apply_stimulus(1);
    cap_done = 0;
    check_output("full_buf_ready", 32'(buf_ready), 1);
    cap_req = 1; cap_addr = 8'h06; cap_data = 8'h11;
    apply_stimulus(1);
    check_output("full_hold_buf_ready", 32'(buf_ready), 1);
    check_output("full_read_index", 32'(read_index), 0);
    disp_req = 1; disp_addr = 8'h31; disp_idle = 1;
    expect_read(9'h031, 1);
    apply_stimulus(1);
    disp_req = 0; disp_idle = 0;
    check_output("swap_read_index", 32'(read_index), 0);
    check_output("swap_buf_ready", 32'(buf_ready), 0);
    apply_stimulus(1);
    check_output("post_swap_read_index", 32'(read_index), 1);
    check_output("post_swap_count", 32'(swap_count), 1);
    check_output("post_swap_buf_ready", 32'(buf_ready), 0);
    expect_write(9'h006, 8'h11);
    apply_stimulus(1);

    // cap_done together with a granted write: write issues, then FULL.
    cap_addr = 8'h07; cap_data = 8'h5C; cap_done = 1;
    expect_write(9'h007, 8'h5C);
    apply_stimulus(1);
    cap_done = 0;
    check_output("done_write_buf_ready", 32'(buf_ready), 1);
    disp_req = 1; disp_addr = 8'h50;
    expect_read(9'h150, 0);
    apply_stimulus(1);
    cap_req = 0; disp_req = 0;

    // Asynchronous reset while FULL with a read response pending.
    #2 reset = 1'b0;
    #1;
    check_output("mid_rst_read_index", 32'(read_index), 0);
    check_output("mid_rst_buf_ready", 32'(buf_ready), 0);
    check_output("mid_rst_rvalid", 32'(disp_rvalid), 0);
    check_output("mid_rst_swap_count", 32'(swap_count), 0);
    apply_stimulus(1);
    reset = 1'b1;

    // Minimum swap path, then run on to the swap counter wrap.
    cap_done = 1; disp_idle = 1;
    apply_stimulus(1);
    check_output("n1_buf_ready", 32'(buf_ready), 1);
    check_output("n1_read_index", 32'(read_index), 0);
    apply_stimulus(1);
    check_output("n2_buf_ready", 32'(buf_ready), 0);
    check_output("n2_read_index", 32'(read_index), 0);
    apply_stimulus(1);
    check_output("n3_read_index", 32'(read_index), 1);
    check_output("n3_swap_count", 32'(swap_count), 1);
    apply_stimulus(3 * 254);
    check_output("swap255_count", 32'(swap_count), 255);
    check_output("swap255_read_index", 32'(read_index), 1);
    apply_stimulus(3);
    check_output("wrap_count", 32'(swap_count), 0);
    check_output("wrap_read_index", 32'(read_index), 0);
    cap_done = 0; disp_idle = 0;
    apply_stimulus(3);

    check_output("grant_queue_empty", 32'(gq.size()), 0);
    check_output("rdata_queue_empty", 32'(rq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
